// File: rtl/master_serial_port.sv
// master_serial_port
// Master-side serial bus port. It takes one parallel request from the core,
// sends a start bit, then the slave ID and the address MSB first, and waits
// for the slave to drop busy. It then either shifts the write data out or
// releases the bus and shifts the read data in, and finally returns a
// one-cycle response to the core.
// Optional feature macro: BUSY_TIMEOUT_EN. When it is defined, a request
// gives up after TIMEOUT_CYCLES busy cycles and completes with rsp_error.
// The input rstn_i is a synchronous reset that is active HIGH, despite its name.

module master_serial_port #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 15,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_rd_wrt_i,
   input  logic [ID_WIDTH-1:0]      req_slave_id_i,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_wdata_i,
   output logic                     rsp_valid_o,
   output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
   output logic                     rsp_error_o,
   output logic                     bus_util_o,
   output logic                     rd_wrt_o,
   output logic                     serial_out_o,
   output logic                     serial_oe_o,
   input  logic                     serial_in_i,
   input  logic                     slave_busy_i
);

   // The bit counter must hold the length of the longest serial phase.
   localparam int MAX_LEN_A = (ID_WIDTH > ADDRESS_WIDTH) ? ID_WIDTH : ADDRESS_WIDTH;
   localparam int MAX_LEN   = (MAX_LEN_A > DATA_WIDTH) ? MAX_LEN_A : DATA_WIDTH;
   localparam int CNT_W     = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ID,
      ADDR,
      WAIT,
      WDATA,
      RDATA,
      DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         bitCnt_q, bitCnt_d;
   logic                     accept;

   logic [ID_WIDTH-1:0]      idSh_q, idSh_d;
   logic [ADDRESS_WIDTH-1:0] addrSh_q, addrSh_d;
   logic [DATA_WIDTH-1:0]    wdSh_q, wdSh_d;
   logic [DATA_WIDTH-1:0]    rdSh_q, rdSh_d;
   logic                     rdWrtLat_q, rdWrtLat_d;

   logic                     reqReady_q, reqReady_d;
   logic                     rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0]    rspRdata_q, rspRdata_d;
   logic                     busUtil_q, busUtil_d;
   logic                     rdWrt_q, rdWrt_d;
   logic                     serialOut_q, serialOut_d;
   logic                     serialOe_q, serialOe_d;

`ifdef BUSY_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0]          busyCnt_q, busyCnt_d;
   logic                     timeoutHit;
   logic                     rspError_q, rspError_d;
`endif

   // A request is taken only while the port is idle; req_ready mirrors IDLE.
   assign accept = (state_q == IDLE) && req_valid_i;

   // Next-state logic: sequence the phases and reload the bit counter on each phase entry.
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
`ifdef BUSY_TIMEOUT_EN
      busyCnt_d  = busyCnt_q;
      timeoutHit = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
            end
         end
         START: begin
            state_d  = ID;
            bitCnt_d = CNT_W'(ID_WIDTH - 1);
         end
         ID: begin
            if (bitCnt_q == '0) begin
               state_d  = ADDR;
               bitCnt_d = CNT_W'(ADDRESS_WIDTH - 1);
            end else begin
               bitCnt_d = bitCnt_q - 1'b1;
            end
         end
         ADDR: begin
            if (bitCnt_q == '0) begin
               state_d = WAIT;
`ifdef BUSY_TIMEOUT_EN
               busyCnt_d = '0;
`endif
            end else begin
               bitCnt_d = bitCnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (!slave_busy_i) begin
               state_d  = rdWrtLat_q ? RDATA : WDATA;
               bitCnt_d = CNT_W'(DATA_WIDTH - 1);
            end
`ifdef BUSY_TIMEOUT_EN
            else if (busyCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_d    = DONE;
               timeoutHit = 1'b1;
            end else begin
               busyCnt_d = busyCnt_q + 1'b1;
            end
`endif
         end
         WDATA, RDATA: begin
            if (bitCnt_q == '0) begin
               state_d = DONE;
            end else begin
               bitCnt_d = bitCnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs: outputs are computed for the state being entered so they line up with it.
   always_comb begin
      idSh_d      = idSh_q;
      addrSh_d    = addrSh_q;
      wdSh_d      = wdSh_q;
      rdSh_d      = rdSh_q;
      rdWrtLat_d  = rdWrtLat_q;
      rspRdata_d  = rspRdata_q;
      busUtil_d   = 1'b0;
      serialOe_d  = 1'b0;
      serialOut_d = 1'b1;
      reqReady_d  = (state_d == IDLE);
      rspValid_d  = (state_d == DONE);
`ifdef BUSY_TIMEOUT_EN
      rspError_d  = timeoutHit;
`endif

      if (accept) begin
         idSh_d     = req_slave_id_i;
         addrSh_d   = req_addr_i;
         wdSh_d     = req_wdata_i;
         rdWrtLat_d = req_rd_wrt_i;
      end

      if (state_q == RDATA) begin
         rdSh_d = {rdSh_q[DATA_WIDTH-2:0], serial_in_i};
         if (state_d == DONE) begin
            rspRdata_d = {rdSh_q[DATA_WIDTH-2:0], serial_in_i};
         end
      end

`ifdef BUSY_TIMEOUT_EN
      if (timeoutHit) begin
         rspRdata_d = '0;
      end
`endif

      case (state_d)
         START: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b1;
            serialOut_d = 1'b0;
         end
         ID: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b1;
            serialOut_d = idSh_q[ID_WIDTH-1];
            idSh_d      = idSh_q << 1;
         end
         ADDR: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b1;
            serialOut_d = addrSh_q[ADDRESS_WIDTH-1];
            addrSh_d    = addrSh_q << 1;
         end
         WAIT: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b1;
            serialOut_d = 1'b1;
         end
         WDATA: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b1;
            serialOut_d = wdSh_q[DATA_WIDTH-1];
            wdSh_d      = wdSh_q << 1;
         end
         RDATA: begin
            busUtil_d   = 1'b1;
            serialOe_d  = 1'b0;
            serialOut_d = 1'b1;
         end
         default: begin
            busUtil_d   = 1'b0;
         end
      endcase

      rdWrt_d = busUtil_d ? rdWrtLat_d : 1'b0;
   end

   // State, counter, shift and output registers with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (rstn_i) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         idSh_q      <= '0;
         addrSh_q    <= '0;
         wdSh_q      <= '0;
         rdSh_q      <= '0;
         rdWrtLat_q  <= 1'b0;
         reqReady_q  <= 1'b1;
         rspValid_q  <= 1'b0;
         rspRdata_q  <= '0;
         busUtil_q   <= 1'b0;
         rdWrt_q     <= 1'b0;
         serialOut_q <= 1'b1;
         serialOe_q  <= 1'b0;
`ifdef BUSY_TIMEOUT_EN
         busyCnt_q   <= '0;
         rspError_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         idSh_q      <= idSh_d;
         addrSh_q    <= addrSh_d;
         wdSh_q      <= wdSh_d;
         rdSh_q      <= rdSh_d;
         rdWrtLat_q  <= rdWrtLat_d;
         reqReady_q  <= reqReady_d;
         rspValid_q  <= rspValid_d;
         rspRdata_q  <= rspRdata_d;
         busUtil_q   <= busUtil_d;
         rdWrt_q     <= rdWrt_d;
         serialOut_q <= serialOut_d;
         serialOe_q  <= serialOe_d;
`ifdef BUSY_TIMEOUT_EN
         busyCnt_q   <= busyCnt_d;
         rspError_q  <= rspError_d;
`endif
      end
   end

   assign req_ready_o  = reqReady_q;
   assign rsp_valid_o  = rspValid_q;
   assign rsp_rdata_o  = rspRdata_q;
   assign bus_util_o   = busUtil_q;
   assign rd_wrt_o     = rdWrt_q;
   assign serial_out_o = serialOut_q;
   assign serial_oe_o  = serialOe_q;

`ifdef BUSY_TIMEOUT_EN
   assign rsp_error_o  = rspError_q;
`else
   assign rsp_error_o  = 1'b0;
`endif

endmodule
